// File: rtl/memshare_rqst_serializer_if.sv
// Request-flag / grant bundle between the skid-buffered request stage, the serializer
// and the shared memory port. Signal suffixes are from the serializer's point of view.
`timescale 1ns/1ps

interface memshare_rqst_serializer_if #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int IDX_W            = $clog2(SHARE_GROUP_SIZE),
    parameter int CNT_W            = 16
);
    logic                        rqst_valid_i;
    logic [SHARE_GROUP_SIZE-1:0] rqst_flag_i;
    logic                        rqst_ready_o;
    logic                        grant_valid_o;
    logic [IDX_W-1:0]            grant_idx_o;
    logic [SHARE_GROUP_SIZE-1:0] grant_onehot_o;
    logic                        grant_last_o;
    logic                        grant_ready_i;
    logic                        busy_o;
    logic [CNT_W-1:0]            batch_cnt_o;

    // Serializer side.
    modport slave (
        input  rqst_valid_i, rqst_flag_i, grant_ready_i,
        output rqst_ready_o, grant_valid_o, grant_idx_o, grant_onehot_o,
               grant_last_o, busy_o, batch_cnt_o
    );

    // Request producer / grant consumer side.
    modport master (
        output rqst_valid_i, rqst_flag_i, grant_ready_i,
        input  rqst_ready_o, grant_valid_o, grant_idx_o, grant_onehot_o,
               grant_last_o, busy_o, batch_cnt_o
    );
endinterface

// File: rtl/memshare_rqst_serializer.sv
// Turns one share-group request-flag vector into a stream of single grants, round-robin,
// with the priority pointer carried across batches so no requestor starves.
`timescale 1ns/1ps

module memshare_rqst_serializer #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int IDX_W            = $clog2(SHARE_GROUP_SIZE),
    parameter int CNT_W            = 16
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    memshare_rqst_serializer_if.slave     bus
);
    localparam int N = SHARE_GROUP_SIZE;
    localparam logic [N-1:0]     ONE_N    = N'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   SUM_N    = (IDX_W + 1)'(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] batch_cnt_q, batch_cnt_d;

    logic [2*N-1:0]   pend_rot;
    logic [IDX_W-1:0] pick_off;
    logic [IDX_W:0]   pick_sum;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_oh;
    logic             pick_single;

    logic gnt_valid;
    logic gnt_last;
    logic gnt_hs;
    logic rqst_ready;
    logic accept;
    logic accept_nz;

    // Rotate pending so bit 0 is the requestor at rr_ptr; the lowest set bit of the
    // rotated view is then the round-robin winner's distance from the pointer.
    assign pend_rot = {pending_q, pending_q} >> rr_ptr_q;

    always_comb begin : rr_pick
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        pick_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_rot[i]) pick_off = IDX_W'(i);
        end
        pick_sum    = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        pick_idx    = (pick_sum >= SUM_N) ? IDX_W'(pick_sum - SUM_N) : pick_sum[IDX_W-1:0];
        pick_oh     = ONE_N << pick_idx;
        pick_single = (pending_q != '0) && ((pending_q & (pending_q - ONE_N)) == '0);
    end

    // State register: synchronous active-low reset clears every register.
    always_ff @(posedge sys_clk) begin : state_reg
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from the values seen before the edge.
            state_q     <= IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            batch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            batch_cnt_q <= batch_cnt_d;
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        batch_cnt_d = batch_cnt_q;
        case (state_q)
            IDLE: begin
                // An all-zero vector is consumed here and simply dropped.
                if (accept_nz) begin
                    pending_d = bus.rqst_flag_i;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                if (gnt_hs) begin
                    pending_d = pending_q & ~pick_oh;
                    rr_ptr_d  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
                    if (gnt_last) begin
                        batch_cnt_d = batch_cnt_q + CNT_W'(1);
                        if (accept_nz) begin
                            pending_d = bus.rqst_flag_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        gnt_valid  = (state_q == SERVE);
        gnt_last   = gnt_valid & pick_single;
        gnt_hs     = gnt_valid & bus.grant_ready_i;
        // Ready during the final grant handshake lets the next batch start with no bubble.
        rqst_ready = (state_q == IDLE) | (gnt_last & bus.grant_ready_i);
        accept     = bus.rqst_valid_i & rqst_ready;
        accept_nz  = accept & (bus.rqst_flag_i != '0);

        bus.rqst_ready_o   = rqst_ready;
        bus.grant_valid_o  = gnt_valid;
        bus.grant_idx_o    = gnt_valid ? pick_idx : '0;
        bus.grant_onehot_o = gnt_valid ? pick_oh : '0;
        bus.grant_last_o   = gnt_last;
        bus.busy_o         = gnt_valid;
        bus.batch_cnt_o    = batch_cnt_q;
    end
endmodule

// File: tb/tb_memshare_rqst_serializer.sv
// Self-checking bench: directed cycle table, hand-written multi-cycle sequences and a
// randomized run against a transaction-level round-robin reference model.
`timescale 1ns/1ps

module tb_memshare_rqst_serializer;
    localparam int N     = 5;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = 16;
    localparam int RAND_CYCLES = 3000;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    memshare_rqst_serializer_if #(.SHARE_GROUP_SIZE(N), .CNT_W(CNT_W)) bus();

    memshare_rqst_serializer #(.SHARE_GROUP_SIZE(N), .CNT_W(CNT_W)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic             v;
        logic [N-1:0]     f;
        logic             gr;
        logic             rdy;
        logic             gv;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic gv,
                              input logic [IDX_W-1:0] idx, input logic last,
                              input logic busy, input logic [CNT_W-1:0] cnt);
        logic [N-1:0] oh;
        oh = '0;
        if (gv) oh[idx] = 1'b1;
        check({tag, " rqst_ready"},   32'(bus.rqst_ready_o),   32'(rdy));
        check({tag, " grant_valid"},  32'(bus.grant_valid_o),  32'(gv));
        check({tag, " grant_idx"},    32'(bus.grant_idx_o),    32'(idx));
        check({tag, " grant_onehot"}, 32'(bus.grant_onehot_o), 32'(oh));
        check({tag, " grant_last"},   32'(bus.grant_last_o),   32'(last));
        check({tag, " busy"},         32'(bus.busy_o),         32'(busy));
        check({tag, " batch_cnt"},    32'(bus.batch_cnt_o),    32'(cnt));
    endtask

    // Drive inputs just after the rising edge, return at the falling edge for sampling.
    task automatic drive(input logic v, input logic [N-1:0] f, input logic gr);
        @(posedge sys_clk);
        #1;
        bus.rqst_valid_i  = v;
        bus.rqst_flag_i   = f;
        bus.grant_ready_i = gr;
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1;
        rstn              = 1'b0;
        bus.rqst_valid_i  = 1'b0;
        bus.rqst_flag_i   = '0;
        bus.grant_ready_i = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        @(negedge sys_clk);
    endtask

    // Reference model: a batch is the list of set requestors ordered by their
    // distance from the priority pointer; grants pop from that list.
    int               exp_q[$];
    int               m_ptr;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_load(input logic [N-1:0] f);
        exp_q.delete();
        for (int d = 0; d < N; d++) begin
            if (f[(m_ptr + d) % N]) exp_q.push_back((m_ptr + d) % N);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rqst_valid_i  = 1'b0;
        bus.rqst_flag_i   = '0;
        bus.grant_ready_i = 1'b0;

        //             v     f         gr     rdy   gv    idx   last  busy  cnt
        vecs[0]  = '{1'b1, 5'b10101, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 16'd0};
        vecs[4]  = '{1'b1, 5'b00100, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 16'd1};
        vecs[6]  = '{1'b1, 5'b01001, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd2};
        vecs[7]  = '{1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 16'd2};
        vecs[8]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'd2};
        vecs[9]  = '{1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd3};
        vecs[10] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd3};
        vecs[11] = '{1'b1, 5'b00001, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd3};
        vecs[12] = '{1'b1, 5'b00010, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'd3};
        vecs[13] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 16'd4};
        vecs[14] = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd5};

        do_reset();
        expect_out("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

        // Directed table: round-robin order, pointer carry, zero vector, back-to-back.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].f, vecs[i].gr);
            expect_out($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].gv, vecs[i].idx,
                       vecs[i].last, vecs[i].busy, vecs[i].cnt);
        end

        // Reset mid-batch: pointer is 2, so 5'b11111 grants 2 then 3 before reset hits.
        drive(1'b1, 5'b11111, 1'b1);
        expect_out("mid_rst accept", 1'b1, 1'b0, '0, 1'b0, 1'b0, 16'd5);
        drive(1'b0, '0, 1'b1);
        expect_out("mid_rst g0", 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'd5);
        drive(1'b0, '0, 1'b1);
        expect_out("mid_rst g1", 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 16'd5);
        @(posedge sys_clk);
        #1;
        rstn              = 1'b0;
        bus.grant_ready_i = 1'b0;
        @(negedge sys_clk);
        expect_out("mid_rst pre", 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 16'd5);
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        @(negedge sys_clk);
        expect_out("mid_rst post", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        drive(1'b1, 5'b10000, 1'b1);
        expect_out("mid_rst new", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b1);
        expect_out("mid_rst g4", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, '0);
        drive(1'b0, '0, 1'b0);
        expect_out("mid_rst idle", 1'b1, 1'b0, '0, 1'b0, 1'b0, 16'd1);

        // Backpressure: grant held stable, competing request ignored while busy.
        drive(1'b1, 5'b00110, 1'b0);
        expect_out("bp accept", 1'b1, 1'b0, '0, 1'b0, 1'b0, 16'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'b11111, 1'b0);
            expect_out($sformatf("bp hold%0d", i), 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 16'd1);
        end
        drive(1'b0, '0, 1'b1);
        expect_out("bp g1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 16'd1);
        drive(1'b0, '0, 1'b1);
        expect_out("bp g2", 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 16'd1);
        drive(1'b0, '0, 1'b0);
        expect_out("bp idle", 1'b1, 1'b0, '0, 1'b0, 1'b0, 16'd2);

        // Randomized traffic against the reference model.
        do_reset();
        exp_q.delete();
        m_ptr = 0;
        m_cnt = '0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            logic             v, gr, e_gv, e_last, e_rdy;
            logic [N-1:0]     f;
            logic [IDX_W-1:0] e_idx;
            int               g;
            v  = ($urandom_range(0, 1) == 1);
            gr = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            drive(v, f, gr);

            e_gv   = (exp_q.size() != 0);
            e_idx  = e_gv ? IDX_W'(exp_q[0]) : '0;
            e_last = (exp_q.size() == 1);
            e_rdy  = !e_gv || (e_last && gr);
            expect_out("rand", e_rdy, e_gv, e_idx, e_last, e_gv, m_cnt);

            if (e_gv && gr) begin
                g     = exp_q.pop_front();
                m_ptr = (g == N - 1) ? 0 : g + 1;
                if (exp_q.size() == 0) m_cnt = m_cnt + 1'b1;
            end
            if (v && e_rdy && (f != '0)) model_load(f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
